// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scancode receiver
//
// Contents:
//   ps2_state_e     frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_PREFIX_EXT  extended-key prefix byte (E0)
//   PS2_PREFIX_BRK  break (key release) prefix byte (F0)
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - byte/key result bundle of the PS/2 receiver
//
// Signals:
//   byte_data  [7:0]  last accepted frame byte
//   byte_valid        one-cycle pulse per accepted byte
//   key_code   [7:0]  last non-prefix byte
//   key_break         key_code was preceded by F0
//   key_ext           key_code was preceded by E0
//   key_valid         one-cycle pulse per completed key event
//   hist       [31:0] last four accepted bytes, newest in [7:0]
//   frame_err         sticky framing/parity/timeout error
// Modports: master = receiver (drives), slave = consumer (display stage).
interface ps2_scancode_rx_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [7:0]  key_code;
  logic        key_break;
  logic        key_ext;
  logic        key_valid;
  logic [31:0] hist;
  logic        frame_err;

  modport master (
    output byte_data, byte_valid, key_code, key_break, key_ext, key_valid, hist, frame_err
  );

  modport slave (
    input byte_data, byte_valid, key_code, key_break, key_ext, key_valid, hist, frame_err
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - PS/2 line synchronizers, clock glitch filter, fall detect
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset (already release-synchronized)
//   ps2_clk_i  raw keyboard clock (asynchronous)
//   ps2_dat_i  raw keyboard data (asynchronous)
//   sample_o   one-cycle pulse on each falling edge of the filtered clock
//   dat_o      synchronized keyboard data
module ps2_sync_filter #(
  parameter int FILT_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic sample_o,
  output logic dat_o
);

  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC + 1) : 1;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] cnt_q;
  logic          fall_q;

  // Both lines idle high, so the synchronizers reset to 1 and the filter
  // starts in the "clock high" state; no spurious edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        // Any return to the accepted level restarts the stability window.
        cnt_q <= '0;
      end else if (cnt_q == FW'(FILT_CYC - 1)) begin
        filt_q <= clk_sync_q[1];
        cnt_q  <= '0;
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + FW'(1);
      end
    end
  end

  assign sample_o = fall_q;
  assign dat_o    = dat_sync_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver with scancode prefix decode
//
// Ports:
//   CLOCK_50  system clock, 50 MHz
//   resetn    asynchronous active-low reset (KEY[0])
//   PS2_CLK   raw keyboard clock
//   PS2_DAT   raw keyboard data
//   rx_if     result bundle (master): byte_data/byte_valid, key_code/key_break/
//             key_ext/key_valid, hist, frame_err
// Parameters:
//   FILT_CYC     cycles PS2_CLK must be stable before a level is accepted
//   TIMEOUT_CYC  idle cycles inside a frame before it is aborted
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, frames with even data+parity ones are dropped
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILT_CYC    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                PS2_CLK,
  input  logic                PS2_DAT,
  ps2_scancode_rx_if.master   rx_if
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Reset asserts immediately but releases two clocks later, so no flop
  // leaves reset on an edge metastable with respect to resetn.
  logic rst_meta_q, rst_n;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rst_meta_q <= 1'b0;
      rst_n      <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n      <= rst_meta_q;
    end
  end

  logic sample, dat;

  ps2_sync_filter #(.FILT_CYC(FILT_CYC)) u_filt (
    .clk_i     (CLOCK_50),
    .rst_ni    (rst_n),
    .ps2_clk_i (PS2_CLK),
    .ps2_dat_i (PS2_DAT),
    .sample_o  (sample),
    .dat_o     (dat)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          accept, err_set;
  logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  // Odd parity over data plus parity bit.
  assign parity_ok = ^{shift_q, par_q};
`else
  // Parity bit is consumed by the PARITY->STOP transition and otherwise ignored.
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    accept    = 1'b0;
    err_set   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        // A high sample here is just an idle line, not an error.
        if (sample && !dat) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = dat;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          if (dat && parity_ok) accept  = 1'b1;
          else                  err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inactivity watchdog, only meaningful while a frame is open.
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (sample) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_set = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  logic [7:0]  byte_data_q, key_code_q;
  logic [31:0] hist_q;
  logic        byte_valid_q, key_valid_q, key_break_q, key_ext_q;
  logic        frame_err_q, ext_pend_q, brk_pend_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      key_code_q   <= '0;
      key_break_q  <= 1'b0;
      key_ext_q    <= 1'b0;
      key_valid_q  <= 1'b0;
      hist_q       <= '0;
      frame_err_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      byte_valid_q <= accept;
      key_valid_q  <= 1'b0;
      if (err_set) frame_err_q <= 1'b1;
      if (accept) begin
        byte_data_q <= shift_q;
        hist_q      <= {hist_q[23:0], shift_q};
        if (shift_q == PS2_PREFIX_EXT) begin
          ext_pend_q <= 1'b1;
        end else if (shift_q == PS2_PREFIX_BRK) begin
          brk_pend_q <= 1'b1;
        end else begin
          key_code_q  <= shift_q;
          key_break_q <= brk_pend_q;
          key_ext_q   <= ext_pend_q;
          key_valid_q <= 1'b1;
          ext_pend_q  <= 1'b0;
          brk_pend_q  <= 1'b0;
        end
      end
    end
  end

  assign rx_if.byte_data  = byte_data_q;
  assign rx_if.byte_valid = byte_valid_q;
  assign rx_if.key_code   = key_code_q;
  assign rx_if.key_break  = key_break_q;
  assign rx_if.key_ext    = key_ext_q;
  assign rx_if.key_valid  = key_valid_q;
  assign rx_if.hist       = hist_q;
  assign rx_if.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed scoreboard bench for ps2_scancode_rx
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int FILT    = 8;
  localparam int TMO     = 2000;
  localparam int HALF    = 30;
  localparam int GAP     = 100;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic PS2_CLK  = 1'b1;
  logic PS2_DAT  = 1'b1;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_scancode_rx_if rx_if ();

  ps2_scancode_rx #(.FILT_CYC(FILT), .TIMEOUT_CYC(TMO)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .rx_if    (rx_if.master)
  );

  typedef struct packed { logic [7:0] b; logic [31:0] h; } exp_byte_t;
  typedef struct packed { logic [7:0] code; logic brk; logic ext; } exp_key_t;

  exp_byte_t byte_q[$];
  exp_key_t  key_q[$];
  logic [31:0] m_hist;
  logic        m_ext, m_brk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of an accepted byte.
  task automatic expect_byte(input logic [7:0] b);
    exp_key_t k;
    m_hist = {m_hist[23:0], b};
    byte_q.push_back('{b: b, h: m_hist});
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = '{code: b, brk: m_brk, ext: m_ext};
      key_q.push_back(k);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  exp_byte_t eb;
  exp_key_t  ek;
  always @(negedge CLOCK_50) begin
    if (rx_if.byte_valid) begin
      if (byte_q.size() == 0) chk("unexpected_byte_valid", 32'd1, 32'd0);
      else begin
        eb = byte_q.pop_front();
        chk("byte_data", 32'(rx_if.byte_data), 32'(eb.b));
        chk("hist", rx_if.hist, eb.h);
      end
    end
    if (rx_if.key_valid) begin
      if (key_q.size() == 0) chk("unexpected_key_valid", 32'd1, 32'd0);
      else begin
        ek = key_q.pop_front();
        chk("key_code", 32'(rx_if.key_code), 32'(ek.code));
        chk("key_break", 32'(rx_if.key_break), 32'(ek.brk));
        chk("key_ext", 32'(rx_if.key_ext), 32'(ek.ext));
      end
    end
  end

  task automatic do_reset();
    @(posedge CLOCK_50);
    resetn = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    resetn = 1'b1;
    m_hist = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    repeat (6) @(posedge CLOCK_50);
  endtask

  // bits[0] is the start bit; the device changes data while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DAT = bits[i];
      repeat (HALF) @(posedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (HALF) @(posedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic accepted);
    logic par;
    par = (~^b) ^ bad_par;
    if (accepted) expect_byte(b);
    send_bits({1'b1, par, b, 1'b0}, 11);
    repeat (GAP) @(posedge CLOCK_50);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_hist = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_byte_data", 32'(rx_if.byte_data), 32'h0);
    chk("rst_byte_valid", 32'(rx_if.byte_valid), 32'h0);
    chk("rst_key_code", 32'(rx_if.key_code), 32'h0);
    chk("rst_key_break", 32'(rx_if.key_break), 32'h0);
    chk("rst_key_ext", 32'(rx_if.key_ext), 32'h0);
    chk("rst_key_valid", 32'(rx_if.key_valid), 32'h0);
    chk("rst_hist", rx_if.hist, 32'h0);
    chk("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
    resetn = 1'b1;
    repeat (6) @(posedge CLOCK_50);

    // Single make code.
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("a_hist", rx_if.hist, 32'h0000001C);
    chk("a_key_code", 32'(rx_if.key_code), 32'h1C);

    // Break sequence.
    do_reset();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("brk_hist", rx_if.hist, 32'h0000F01C);
    chk("brk_key_break", 32'(rx_if.key_break), 32'h1);

    // Extended break followed by extended-free make.
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("ext_key_ext_cleared", 32'(rx_if.key_ext), 32'h0);
    chk("ext_err_clean", 32'(rx_if.frame_err), 32'h0);

    // Wrong parity.
    do_reset();
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("par_frame_err", 32'(rx_if.frame_err), 32'h1);
    chk("par_hist", rx_if.hist, 32'h0);
`else
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_frame_err", 32'(rx_if.frame_err), 32'h0);
    chk("par_hist", rx_if.hist, 32'h0000001C);
`endif

    // Bad stop bit drops the byte and sets the sticky error.
    do_reset();
    send_bits({1'b0, 1'b1, 8'h33, 1'b0}, 11);
    repeat (GAP) @(posedge CLOCK_50);
    chk("stop_frame_err", 32'(rx_if.frame_err), 32'h1);
    chk("stop_hist", rx_if.hist, 32'h0);

    // Timeout after start + 4 data bits, then a good frame.
    do_reset();
    send_bits({3'b110, 8'h05, 1'b0}, 5);
    repeat (TMO / 2) @(posedge CLOCK_50);
    chk("tmo_in_frame", 32'(dut.state_q != IDLE), 32'h1);
    repeat (TMO / 2 + 50) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("tmo_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("tmo_frame_err", 32'(rx_if.frame_err), 32'h1);
    chk("tmo_hist_kept", rx_if.hist, 32'h0);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("tmo_next_code", 32'(rx_if.key_code), 32'h29);

    // Reset mid-frame, then a fresh frame.
    send_bits({3'b110, 8'h0A, 1'b0}, 5);
    resetn = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    resetn = 1'b1;
    m_hist = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    send_frame(8'h16, 1'b0, 1'b1);
    chk("midrst_key_code", 32'(rx_if.key_code), 32'h16);
    chk("midrst_hist", rx_if.hist, 32'h00000016);
    chk("midrst_frame_err", 32'(rx_if.frame_err), 32'h0);

    // 3-cycle clock glitch with data low must not start a frame.
    PS2_DAT = 1'b0;
    repeat (HALF) @(posedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (HALF) @(posedge CLOCK_50);
    PS2_DAT = 1'b1;
    @(negedge CLOCK_50);
    chk("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("glitch_frame_err", 32'(rx_if.frame_err), 32'h0);

    repeat (GAP) @(posedge CLOCK_50);
    chk("byte_queue_drained", 32'(byte_q.size()), 32'd0);
    chk("key_queue_drained", 32'(key_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILT_CYC, default 8: consecutive CLOCK_50 cycles a synchronized PS2_CLK level must hold before it is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 100000: idle CLOCK_50 cycles (2 ms) inside a frame before the frame is aborted.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 CLOCK_50  input  1  system clock, 50 MHz; all state on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset, driven from KEY[0] at top level.
REQ-006 PS2_CLK  input  1  raw keyboard clock, asynchronous.
REQ-007 PS2_DAT  input  1  raw keyboard data, asynchronous.
REQ-008 byte_data  output  8  last accepted frame byte.
REQ-009 byte_valid  output  1  one-cycle pulse per accepted byte.
REQ-010 key_code  output  8  last non-prefix byte.
REQ-011 key_break  output  1  key_code was preceded by F0.
REQ-012 key_ext  output  1  key_code was preceded by E0.
REQ-013 key_valid  output  1  one-cycle pulse per completed key event.
REQ-014 hist  output  32  last four accepted bytes, newest in [7:0], for the HEX0..HEX7 display stage.
REQ-015 frame_err  output  1  sticky: framing, parity or timeout error seen.

Function
REQ-016 PS2_CLK and PS2_DAT SHALL each pass a 2-flop synchronizer; PS2_CLK then passes a FILT_CYC stability filter.
REQ-017 A falling edge of the filtered clock SHALL be the only sample event; PS2_DAT (synchronized) is sampled at that event.
REQ-018 FSM states: IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: sample 0 -> DATA with bit count 0; sample 1 -> stay IDLE, no error.
REQ-020 DATA: shift sample in LSB first; after 8th sample -> PARITY.
REQ-021 PARITY: capture sample -> STOP.
REQ-022 STOP: sample 1 -> accept byte (subject to REQ-036); sample 0 -> frame_err=1, byte dropped; either case -> IDLE.
REQ-023 Outside IDLE, TIMEOUT_CYC cycles without a sample event SHALL force IDLE, set frame_err, discard partial byte; timeout counter resets on every sample event.
REQ-024 On acceptance, in the cycle after the stop-bit sample event: byte_data updated, byte_valid=1 for exactly one cycle, hist <= {hist[23:0], byte}.
REQ-025 Accepted 0xE0 SHALL set ext_pending; accepted 0xF0 SHALL set brk_pending; neither pulses key_valid.
REQ-026 Any other accepted byte SHALL, in the same cycle as byte_valid: load key_code, key_break=brk_pending, key_ext=ext_pending, pulse key_valid, clear both pendings.
REQ-027 Dropped or timed-out frames SHALL not alter pendings, hist, byte_data or key outputs.
REQ-028 frame_err SHALL clear only on reset.

Reset
REQ-029 resetn low SHALL asynchronously force: FSM IDLE, bit count 0, timeout counter 0, filter state to "clock high".
REQ-030 Reset values: byte_data=0, byte_valid=0, key_code=0, key_break=0, key_ext=0, key_valid=0, hist=0, frame_err=0, pendings=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release the next start bit begins a fresh frame.
REQ-032 Release SHALL be synchronized to CLOCK_50 internally (2-flop release) before FSM use.

Configuration
REQ-033 Macro PS2_PARITY_CHECK_EN selects parity checking.
REQ-034 Defined: byte accepted only if data plus parity bit has odd count of ones; otherwise frame_err=1 and byte dropped.
REQ-035 Undefined: parity bit captured and ignored; no parity logic synthesized.
REQ-036 Acceptance in REQ-022 SHALL be gated by REQ-034 when the macro is defined.

Structure
REQ-037 Shared package ps2_pkg SHALL hold the FSM state enum, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0.
REQ-038 Sub-module ps2_sync_filter SHALL contain synchronizers, stability filter and falling-edge pulse; FSM and prefix logic stay in ps2_scancode_rx.

Verification
REQ-039 Frame 0x1C (A), parity 0, stop 1 -> byte_valid once, key_code=0x1C, key_break=0, key_ext=0, hist=0x0000001C.
REQ-040 Bytes F0,1C -> two byte_valid, one key_valid with key_code=0x1C, key_break=1; hist=0x0000F01C.
REQ-041 Bytes E0,F0,75 -> one key_valid, key_code=0x75, key_break=1, key_ext=1; next byte 0x75 -> key_break=0, key_ext=0.
REQ-042 Frame 0x1C with parity 1, macro defined -> no byte_valid, frame_err=1; macro undefined -> byte accepted, frame_err=0.
REQ-043 Stop clocks after 4 data bits -> after 100000 cycles FSM IDLE, frame_err=1; following good frame 0x29 accepted.
REQ-044 Assert resetn mid-frame after 5 bits, release, send 0x16 -> key_code=0x16, hist=0x00000016, frame_err=0; 3-cycle glitch on PS2_CLK -> no sample event.
